// File: rtl/key_expansion_seq.sv
// key_expansion_seq: iterative AES-128 key schedule, one round key per clock after start.
module key_expansion_seq #(
  parameter int NUM_ROUNDS = 10
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start,
  input  logic [127:0]                      key,
  output logic [(NUM_ROUNDS+1)*128-1:0]     expanded_key,
  output logic                              busy,
  output logic                              finish
);
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };
  localparam logic [79:0] RCON = 80'h0102040810204080_1b36;
  typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;
  state_t state;
  logic [3:0] rnd, ri;
  logic [127:0] last;
  logic [31:0] w3, temp, n0, n1, n2, n3;
  function automatic logic [7:0] sub(input logic [7:0] b);
    return SBOX[{~b, 3'b000} +: 8];
  endfunction
  // last holds the most recently written round key, so slot rnd-1 never needs a variable read
  always_comb begin
    w3 = last[31:0];
    ri = 4'(NUM_ROUNDS) - rnd;
    temp = {sub(w3[23:16]), sub(w3[15:8]), sub(w3[7:0]), sub(w3[31:24])} ^ {RCON[{ri, 3'b000} +: 8], 24'h0};
    n0 = last[127:96] ^ temp;
    n1 = last[95:64] ^ n0;
    n2 = last[63:32] ^ n1;
    n3 = w3 ^ n2;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      expanded_key <= '0;
      busy <= 1'b0;
      finish <= 1'b0;
      rnd <= '0;
      last <= '0;
    end else begin
      case (state)
        IDLE, DONE: if (start) begin
          expanded_key <= {{NUM_ROUNDS*128{1'b0}}, key};
          last <= key;
          rnd <= 4'd1;
          busy <= 1'b1;
          finish <= 1'b0;
          state <= EXPAND;
        end
        EXPAND: begin
          for (int i = 1; i <= NUM_ROUNDS; i++)
            if (rnd == i[3:0]) expanded_key[i*128 +: 128] <= {n0, n1, n2, n3};
          last <= {n0, n1, n2, n3};
          rnd <= rnd + 4'd1;
          if (rnd == 4'(NUM_ROUNDS)) begin
            busy <= 1'b0;
            finish <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/key_expansion_seq.md
Name: key_expansion_seq

Overview:
- Iterative AES-128 key schedule that produces the 1408-bit expanded key consumed by the round-key XOR stage.
- Takes the 128-bit cipher key on a start pulse and derives one round key per clock, 10 expansion cycles in total.
- Raises finish when all 11 round keys are valid.
- Sits directly upstream of addroundkey: expanded_key here connects straight to its key input.

Parameters:
- NUM_ROUNDS, 10, number of derived round keys. expanded_key width = (NUM_ROUNDS+1)*128. Only 10 is supported; the Rcon table holds exactly 10 entries.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  begin expansion; sampled only when not busy
- key  input  128  cipher key; byte 0 at [127:120]; sampled on the accepted start edge only
- expanded_key  output  1408  round key r at [r*128 +: 128]; within a round key, word w0 at [127:96]
- busy  output  1  high while expansion is in progress
- finish  output  1  high while all 11 round keys are valid

Behaviour:
- Clock and reset:
  - One clock domain: clk.
  - rst is synchronous and active-high. It dominates start.
- Reset values: state=IDLE, expanded_key=0, busy=0, finish=0, round counter=0.
- FSM states: IDLE, EXPAND, DONE.
- Accepting start (in IDLE or DONE, start=1 at edge E0):
  - slot 0 <= key; slots 1..10 <= 0.
  - rnd <= 1; busy <= 1; finish <= 0; go to EXPAND.
- EXPAND, one round key per edge E1..E10 (slot rnd is derived from slot rnd-1):
  - temp = SubWord(RotWord(w3)) ^ {Rcon[rnd], 24'h0}
  - n0 = w0 ^ temp; n1 = w1 ^ n0; n2 = w2 ^ n1; n3 = w3 ^ n2
  - Write {n0,n1,n2,n3} to slot rnd; rnd increments.
- Helper definitions:
  - RotWord: {b0,b1,b2,b3} -> {b1,b2,b3,b0}.
  - SubWord: standard AES S-box on each byte, implemented as an internal combinational lookup.
  - Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
- Completion at edge E10 (slot 10 written): busy <= 0, finish <= 1, go to DONE.
  - Latency: finish goes high on the 10th rising edge after the edge that accepted start.
- DONE:
  - finish stays high and expanded_key stays stable indefinitely.
  - A new start restarts per the accepting-start rule; finish drops on that same edge.
- Start while busy: ignored. The key input is not re-sampled and progress is unaffected.
- Key input changing during EXPAND: no effect, since only the latched slot 0 is used.
- rst mid-expansion: on the next edge, returns to IDLE with all outputs at their reset values. No partial finish.
- busy and finish are never both 1.
- Partial contents during EXPAND:
  - Slots 1..rnd-1 are valid; higher slots read 0.
  - Consumers use expanded_key only while finish=1.

Test Plan:
1. FIPS-197 key
   - Stimulus: rst, then start with key=2b7e151628aed2a6abf7158809cf4f3c.
   - Required response: slot1=a0fafe1788542cb123a339392a6c7605 and slot10=d014f9a8c9ee2589e13f0cc8b6630ca6; finish rises exactly 10 edges after the start edge; busy high for those 10 cycles.
2. All-zero key
   - Stimulus: start with key=0.
   - Required response: slot1=62636363626363636263636362636363, slot10=b4ef5bcb3e92e21123e951cf6f8f188e, slot0=0.
3. Start and key changes while busy
   - Stimulus: start at E0 with the FIPS key; at E4, pulse start with key=0 and toggle key every cycle.
   - Required response: the result is still the FIPS schedule and finish still rises at E10.
4. Mid-expansion reset
   - Stimulus: rst asserted at E5 of an expansion.
   - Required response: on the next edge, busy=0, finish=0, expanded_key=0; finish never asserts; a subsequent start gives the correct result.
5. Restart from DONE
   - Stimulus: after test 1 completes, start with key=0.
   - Required response: finish drops on the start edge; slots 1..10 read 0 on the following cycle; the zero-key schedule completes 10 edges later.
6. Chained with the round-key XOR stage
   - Stimulus: FIPS key; state=3243f6a8885a308d313198a2e0370734; roundnumber=0 once finish=1.
   - Required response: the XOR stage outputs 193de3bea0f4e22b9ac68d2ae9f84808.
